// File: rtl/seq101_pattern_tx.sv
// Serial pattern transmitter: shifts a loaded word out MSB-first, repeated load_reps times,
// while tracking the hits a frame-aligned, non-overlapping 101 Mealy detector should report.
module seq101_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int HIT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_reps,
  input  logic             bit_ready,
  output logic             data_out,
  output logic             data_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             frame_done,
  output logic [HIT_W-1:0] exp_hits
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {M0, M1, M2} mirror_t;

  state_t           state, state_nxt;
  mirror_t          mirror, mirror_nxt;
  logic [WIDTH-1:0] pat_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] reps_reg;
  logic             accept;
  logic             xfer;
  logic             at_bit0;
  logic             last_copy;
  logic             hit;

  assign accept    = load_valid && (state == IDLE);
  assign xfer      = (state == SHIFT) && data_valid && bit_ready;
  assign at_bit0   = (bit_idx == '0);
  assign last_copy = (reps_reg == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (load_reps != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (xfer && at_bit0 && last_copy) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    last_bit   = data_valid && last_copy && at_bit0;
  end

  // shift_reg[WIDTH-1] always mirrors data_out; the next bit is read one position below it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg    <= '0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      reps_reg   <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
    end else if (accept) begin
      pat_reg    <= load_data;
      shift_reg  <= load_data;
      bit_idx    <= IDX_W'(WIDTH - 1);
      reps_reg   <= load_reps;
      data_valid <= (load_reps != '0);
      data_out   <= (load_reps != '0) ? load_data[WIDTH-1] : 1'b0;
    end else if (xfer) begin
      if (!at_bit0) begin
        shift_reg <= shift_reg << 1;
        data_out  <= shift_reg[WIDTH-2];
        bit_idx   <= bit_idx - IDX_W'(1);
      end else if (!last_copy) begin
        shift_reg <= pat_reg;
        data_out  <= pat_reg[WIDTH-1];
        bit_idx   <= IDX_W'(WIDTH - 1);
        reps_reg  <= reps_reg - CNT_W'(1);
      end else begin
        reps_reg   <= reps_reg - CNT_W'(1);
        data_out   <= 1'b0;
        data_valid <= 1'b0;
      end
    end else if (state == DONE) begin
      data_out   <= 1'b0;
      data_valid <= 1'b0;
    end
  end

  always_comb begin
    mirror_nxt = mirror;
    hit        = 1'b0;
    if (xfer) begin
      case (mirror)
        M0:      mirror_nxt = data_out ? M1 : M0;
        M1:      mirror_nxt = data_out ? M1 : M2;
        M2: begin
          mirror_nxt = M0;
          hit        = data_out;
        end
        default: mirror_nxt = M0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mirror   <= M0;
      exp_hits <= '0;
    end else if (accept) begin
      mirror   <= M0;
      exp_hits <= '0;
    end else begin
      mirror <= mirror_nxt;
      if (hit && (exp_hits != '1)) exp_hits <= exp_hits + HIT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq101_pattern_tx.sv
// Bench for seq101_pattern_tx: table of frames checked through a bit scoreboard, plus a
// hand-written busy-load / mid-frame reset sequence.
module tb_seq101_pattern_tx;
  localparam int W  = 8;
  localparam int CW = 8;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  load_data = '0;
  logic [CW-1:0] load_reps = '0;
  logic          bit_ready = 1'b1;
  logic          data_out, data_valid, last_bit, busy, frame_done;
  logic [HW-1:0] exp_hits;

  seq101_pattern_tx #(.WIDTH(W), .CNT_W(CW), .HIT_W(HW)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_reps(load_reps), .bit_ready(bit_ready),
    .data_out(data_out), .data_valid(data_valid), .last_bit(last_bit),
    .busy(busy), .frame_done(frame_done), .exp_hits(exp_hits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           reps;
    int           stall_start;
    int           stall_len;
    int           hits;
  } vec_t;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sbq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Called at the negedge: compare the presented bit against the scoreboard head.
  task automatic sb_sample();
    exp_t e;
    if (data_valid) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq[0];
        check("data_out", 32'(data_out), 32'(e.b));
        check("last_bit", 32'(last_bit), 32'(e.last));
        if (bit_ready) void'(sbq.pop_front());
      end
    end else begin
      check("idle_data_out", 32'(data_out), 32'd0);
      check("idle_last_bit", 32'(last_bit), 32'd0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    int   valid_cnt = 0;
    int   done_c = 0;
    int   stall_hits = 0;
    int   waited = 0;
    @(posedge clk); #1;
    while (!load_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = v.data;
    load_reps  = CW'(v.reps);
    bit_ready  = 1'b1;
    for (int r = 0; r < v.reps; r++)
      for (int i = W - 1; i >= 0; i--) begin
        e.b    = v.data[i];
        e.last = (r == v.reps - 1) && (i == 0);
        sbq.push_back(e);
      end
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (c == 1) load_valid = 1'b0;
      bit_ready = !(v.stall_len > 0 && c >= v.stall_start && c < v.stall_start + v.stall_len);
      @(negedge clk);
      if (c == 1) check("hits_cleared", 32'(exp_hits), 32'd0);
      if (v.stall_len > 0 && c == v.stall_start) stall_hits = int'(exp_hits);
      if (v.stall_len > 0 && c > v.stall_start && c < v.stall_start + v.stall_len)
        check("stall_hits_hold", 32'(exp_hits), 32'(stall_hits));
      sb_sample();
      if (data_valid) valid_cnt++;
      if (frame_done) begin
        done_c = c;
        break;
      end
    end
    bit_ready = 1'b1;
    if (done_c == 0) begin
      $display("FAIL frame_timeout: got no frame_done, expected one at cycle %0d",
               W * v.reps + v.stall_len + 1);
      total_cnt++;
      sbq.delete();
    end else begin
      check("frame_done_cycle", 32'(done_c), 32'(W * v.reps + v.stall_len + 1));
      check("valid_cycles", 32'(valid_cnt), 32'(W * v.reps + v.stall_len));
      check("exp_hits", 32'(exp_hits), 32'(v.hits));
      check("sb_empty", 32'(sbq.size()), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ready_after_done", 32'(load_ready), 32'd1);
      check("done_one_cycle", 32'(frame_done), 32'd0);
      check("hits_hold", 32'(exp_hits), 32'(v.hits));
    end
  endtask

  vec_t vecs[8];
  int   seen_done;
  logic [W-1:0] a5;

  initial begin
    vecs[0] = '{data: 8'hA5, reps: 1, stall_start: 0, stall_len: 0, hits: 2};
    vecs[1] = '{data: 8'hAA, reps: 1, stall_start: 0, stall_len: 0, hits: 2};
    vecs[2] = '{data: 8'hA0, reps: 3, stall_start: 0, stall_len: 0, hits: 3};
    vecs[3] = '{data: 8'hA5, reps: 1, stall_start: 3, stall_len: 3, hits: 2};
    vecs[4] = '{data: 8'hA5, reps: 0, stall_start: 0, stall_len: 0, hits: 0};
    vecs[5] = '{data: 8'hFF, reps: 2, stall_start: 0, stall_len: 0, hits: 0};
    vecs[6] = '{data: 8'h55, reps: 2, stall_start: 5, stall_len: 2, hits: 4};
    vecs[7] = '{data: 8'h41, reps: 2, stall_start: 0, stall_len: 0, hits: 1};

    #12;
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_exp_hits", 32'(exp_hits), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) run_frame(vecs[k]);

    // Busy load attempt, then reset while the 4th bit is on the line.
    a5 = 8'hA5;
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = a5;
    load_reps  = 8'd1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) load_valid = 1'b0;
      if (c == 2) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_reps  = 8'd5;
      end
      if (c == 3) load_valid = 1'b0;
      if (c < 4) begin
        @(negedge clk);
        check("busy_load_bit", 32'(data_out), 32'(a5[W-c]));
        check("busy_flag", 32'(busy), 32'd1);
      end
    end
    check("pre_rst_hits", 32'(exp_hits), 32'd1);
    check("pre_rst_bit4", 32'(data_out), 32'(a5[W-4]));
    rst = 1'b0;
    #1;
    check("abort_data_valid", 32'(data_valid), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_last_bit", 32'(last_bit), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_load_ready", 32'(load_ready), 32'd1);
    check("abort_exp_hits", 32'(exp_hits), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (frame_done || data_valid) seen_done++;
    end
    check("abort_no_frame_done", 32'(seen_done), 32'd0);

    run_frame(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
